// File: rtl/decode_stage_if.sv
// Fetch/decode/writeback bundle around the D stage of the MIPS pipeline.
// The master side is the surrounding pipeline (F/D register, hazard unit,
// forwarding network, W stage). The slave side is decode_stage itself.
interface decode_stage_if;
  // From the F/D register
  logic [31:0] IRD;
  logic [31:0] PC4D;
  logic [4:0]  ExcCodeF;
  // Hazard unit
  logic        StallD;
  logic        exp_in;
  // Forwarding network
  logic [1:0]  FwdSelRS;
  logic [1:0]  FwdSelRT;
  logic [31:0] FwdDataE;
  logic [31:0] FwdDataM;
  // Register-file write-back port
  logic        WE_W;
  logic [4:0]  WA_W;
  logic [31:0] WD_W;
  // Redirect information returned to fetch
  logic [31:0] NPC;
  logic [1:0]  NPC_Sel;
  logic        Branch;
  logic [31:0] MF_RS_D_OUT;
  logic        iseretD;
  // D/E pipeline register
  logic [31:0] IRE;
  logic [31:0] PC4E;
  logic [31:0] RSE;
  logic [31:0] RTE;
  logic [31:0] EXTE;
  logic [4:0]  ExcCodeE;

  modport master (
    output IRD, PC4D, ExcCodeF, StallD, exp_in,
           FwdSelRS, FwdSelRT, FwdDataE, FwdDataM,
           WE_W, WA_W, WD_W,
    input  NPC, NPC_Sel, Branch, MF_RS_D_OUT, iseretD,
           IRE, PC4E, RSE, RTE, EXTE, ExcCodeE
  );

  modport slave (
    input  IRD, PC4D, ExcCodeF, StallD, exp_in,
           FwdSelRS, FwdSelRT, FwdDataE, FwdDataM,
           WE_W, WA_W, WD_W,
    output NPC, NPC_Sel, Branch, MF_RS_D_OUT, iseretD,
           IRE, PC4E, RSE, RTE, EXTE, ExcCodeE
  );
endinterface

// File: rtl/decode_stage.sv
// D stage of the 5-stage MIPS pipeline: register file, operand forwarding,
// branch/jump resolution for fetch, immediate extension, reserved-instruction
// detection and the D/E pipeline register.
module decode_stage #(
  parameter logic [31:0] SP_INIT = 32'h0000_2ffc,
  parameter logic [31:0] GP_INIT = 32'h0000_1800,
  parameter logic [4:0]  EXC_RI  = 5'd10
) (
  input logic           Clk,
  input logic           Reset,
  decode_stage_if.slave dbus
);

  localparam logic [5:0]  OP_SPECIAL = 6'h00;
  localparam logic [5:0]  OP_REGIMM  = 6'h01;
  localparam logic [5:0]  OP_J       = 6'h02;
  localparam logic [5:0]  OP_JAL     = 6'h03;
  localparam logic [5:0]  OP_BEQ     = 6'h04;
  localparam logic [5:0]  OP_BNE     = 6'h05;
  localparam logic [5:0]  OP_BLEZ    = 6'h06;
  localparam logic [5:0]  OP_BGTZ    = 6'h07;
  localparam logic [5:0]  OP_ANDI    = 6'h0c;
  localparam logic [5:0]  OP_ORI     = 6'h0d;
  localparam logic [5:0]  OP_XORI    = 6'h0e;
  localparam logic [5:0]  OP_LUI     = 6'h0f;
  localparam logic [5:0]  OP_COP0    = 6'h10;
  localparam logic [31:0] ERET       = 32'h4200_0018;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [15:0] imm;

  assign op    = dbus.IRD[31:26];
  assign rs    = dbus.IRD[25:21];
  assign rt    = dbus.IRD[20:16];
  assign imm   = dbus.IRD[15:0];
  assign funct = dbus.IRD[5:0];

  logic is_valid;
  logic is_branch;
  logic is_jump;
  logic is_jreg;

  // Instruction classification: legality and control-transfer kind.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path through the case leaves it unassigned (which would infer a latch).
    is_valid  = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    is_jreg   = 1'b0;
    case (op)
      OP_SPECIAL: begin
        is_valid = funct inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                                 6'h08, 6'h09, 6'h10, 6'h11, 6'h12, 6'h13,
                                 6'h18, 6'h19, 6'h1a, 6'h1b, 6'h20, 6'h21,
                                 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                 6'h2a, 6'h2b};
        is_jreg  = funct inside {6'h08, 6'h09};
      end
      OP_REGIMM: begin
        is_valid  = rt inside {5'd0, 5'd1};
        is_branch = rt inside {5'd0, 5'd1};
      end
      OP_J, OP_JAL: begin
        is_valid = 1'b1;
        is_jump  = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        is_valid  = 1'b1;
        is_branch = 1'b1;
      end
      6'h08, 6'h09, 6'h0a, 6'h0b, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2b: begin
        is_valid = 1'b1;
      end
      OP_COP0: begin
        // mfc0 (rs=0), mtc0 (rs=4) or the exact eret encoding.
        is_valid = (rs == 5'd0) || (rs == 5'd4) || (dbus.IRD == ERET);
      end
      default: ;
    endcase
  end

  // Register file: $0 is never stored, reads of it are forced to zero below.
  logic [31:0] regs [32];

  // Register-file update: write-back is independent of StallD; Reset wins.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (Reset) begin
      // NOTE: this array is reset on purpose -- software relies on $28/$29
      // holding GP/SP and every other register reading zero after reset.
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      regs[28] <= GP_INIT;
      regs[29] <= SP_INIT;
    end else if (dbus.WE_W && (dbus.WA_W != 5'd0)) begin
      regs[dbus.WA_W] <= dbus.WD_W;
    end
  end

  // Read ports with write-through bypass from W; $0 never bypasses.
  logic        wb_hit_rs;
  logic        wb_hit_rt;
  logic [31:0] rf_rs;
  logic [31:0] rf_rt;

  assign wb_hit_rs = dbus.WE_W && (dbus.WA_W != 5'd0) && (dbus.WA_W == rs);
  assign wb_hit_rt = dbus.WE_W && (dbus.WA_W != 5'd0) && (dbus.WA_W == rt);
  assign rf_rs = (rs == 5'd0) ? '0 : (wb_hit_rs ? dbus.WD_W : regs[rs]);
  assign rf_rt = (rt == 5'd0) ? '0 : (wb_hit_rt ? dbus.WD_W : regs[rt]);

  logic [31:0] rs_val;
  logic [31:0] rt_val;

  // Operand forwarding: 1 selects M, 2 selects E, 0 and 3 use the regfile.
  always_comb begin
    case (dbus.FwdSelRS)
      2'd1:    rs_val = dbus.FwdDataM;
      2'd2:    rs_val = dbus.FwdDataE;
      default: rs_val = rf_rs;
    endcase
    case (dbus.FwdSelRT)
      2'd1:    rt_val = dbus.FwdDataM;
      2'd2:    rt_val = dbus.FwdDataE;
      default: rt_val = rf_rt;
    endcase
  end

  logic taken;

  // Branch condition on forwarded operands; zero-compares are signed.
  always_comb begin
    taken = 1'b0;
    case (op)
      OP_BEQ:    taken = (rs_val == rt_val);
      OP_BNE:    taken = (rs_val != rt_val);
      OP_BLEZ:   taken = ($signed(rs_val) <= 0);
      OP_BGTZ:   taken = ($signed(rs_val) > 0);
      OP_REGIMM: taken = rt[0] ? ($signed(rs_val) >= 0) : ($signed(rs_val) < 0);
      default:   taken = 1'b0;
    endcase
  end

  logic [31:0] branch_target;
  logic [31:0] jump_target;

  assign branch_target    = dbus.PC4D + {{14{imm[15]}}, imm, 2'b00};
  assign jump_target      = {dbus.PC4D[31:28], dbus.IRD[25:0], 2'b00};
  assign dbus.NPC         = is_jump ? jump_target : branch_target;
  assign dbus.NPC_Sel     = is_branch ? 2'd1 : (is_jump ? 2'd2 : (is_jreg ? 2'd3 : 2'd0));
  assign dbus.Branch      = is_branch & taken;
  assign dbus.MF_RS_D_OUT = rs_val;
  assign dbus.iseretD     = (dbus.IRD == ERET);

  logic [31:0] ext_imm;
  logic [4:0]  exc_d;

  // Immediate extension: logical ops zero-extend, lui shifts, rest sign-extend.
  always_comb begin
    case (op)
      OP_ANDI, OP_ORI, OP_XORI: ext_imm = {16'h0000, imm};
      OP_LUI:                   ext_imm = {imm, 16'h0000};
      default:                  ext_imm = {{16{imm[15]}}, imm};
    endcase
  end

  // An exception already raised in F outranks a reserved instruction.
  assign exc_d = (dbus.ExcCodeF != 5'd0) ? dbus.ExcCodeF
               : (is_valid ? 5'd0 : EXC_RI);

  // D/E register: reset/exception flush and stall both load a bubble.
  always_ff @(posedge Clk) begin
    if (Reset || dbus.exp_in || dbus.StallD) begin
      dbus.IRE      <= '0;
      dbus.PC4E     <= '0;
      dbus.RSE      <= '0;
      dbus.RTE      <= '0;
      dbus.EXTE     <= '0;
      dbus.ExcCodeE <= '0;
    end else begin
      // A reserved instruction travels as a nop so E/M perform no side effects.
      dbus.IRE      <= is_valid ? dbus.IRD : '0;
      dbus.PC4E     <= dbus.PC4D;
      dbus.RSE      <= rs_val;
      dbus.RTE      <= rt_val;
      dbus.EXTE     <= ext_imm;
      dbus.ExcCodeE <= exc_d;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage. A behavioural model of the architectural
// register file and the decode rules predicts the combinational redirect
// outputs and the next D/E register contents; one negedge process compares
// them every cycle. Directed literal checks pin the model to known answers.
module tb_decode_stage;

  localparam logic [31:0] ERET = 32'h4200_0018;

  logic Clk = 1'b0;
  logic Reset;

  decode_stage_if bus ();

  decode_stage dut (
    .Clk   (Clk),
    .Reset (Reset),
    .dbus  (bus)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // ---------------- behavioural model ----------------
  function automatic bit legal(input logic [31:0] ir);
    logic [5:0] op;
    logic [5:0] fn;
    op = ir[31:26];
    fn = ir[5:0];
    if (op == 6'h00)
      return fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                        6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b,
                        6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                        6'h2a, 6'h2b};
    if (op == 6'h01) return ir[20:16] <= 5'd1;
    if (op == 6'h10) return (ir[25:21] == 5'd0) || (ir[25:21] == 5'd4) || (ir == ERET);
    return op inside {6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09,
                      6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h20, 6'h21,
                      6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2b};
  endfunction

  function automatic logic [1:0] want_sel(input logic [31:0] ir);
    if (!legal(ir)) return 2'd0;
    if (ir[31:26] == 6'h00 && (ir[5:0] == 6'h08 || ir[5:0] == 6'h09)) return 2'd3;
    if (ir[31:26] == 6'h02 || ir[31:26] == 6'h03) return 2'd2;
    if (ir[31:26] inside {6'h01, 6'h04, 6'h05, 6'h06, 6'h07}) return 2'd1;
    return 2'd0;
  endfunction

  function automatic bit want_taken(input logic [31:0] ir, input logic [31:0] a,
                                    input logic [31:0] b);
    int sa;
    sa = int'(a);
    case (ir[31:26])
      6'h04:   return a == b;
      6'h05:   return a != b;
      6'h06:   return sa <= 0;
      6'h07:   return sa > 0;
      6'h01:   return ir[16] ? (sa >= 0) : (sa < 0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] want_npc(input logic [31:0] ir, input logic [31:0] pc4);
    int off;
    if (ir[31:26] == 6'h02 || ir[31:26] == 6'h03)
      return {pc4[31:28], ir[25:0], 2'b00};
    off = int'($signed(ir[15:0]));
    return pc4 + 32'(off * 4);
  endfunction

  function automatic logic [31:0] want_ext(input logic [31:0] ir);
    int simm;
    if (ir[31:26] == 6'h0f) return {ir[15:0], 16'h0000};
    if (ir[31:26] inside {6'h0c, 6'h0d, 6'h0e}) return {16'h0000, ir[15:0]};
    simm = int'($signed(ir[15:0]));
    return 32'(simm);
  endfunction

  logic [31:0] m_regs [32];
  bit          m_valid = 1'b0;
  bit          e_valid = 1'b0;
  logic [31:0] x_ire, x_pc4e, x_rse, x_rte, x_exte;
  logic [4:0]  x_exc;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (bus.WE_W && bus.WA_W == a) return bus.WD_W;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] m_fwd(input logic [1:0] sel, input logic [31:0] rf);
    if (sel == 2'd1) return bus.FwdDataM;
    if (sel == 2'd2) return bus.FwdDataE;
    return rf;
  endfunction

  // Per-cycle compare against the model, then advance the model past the next edge.
  always @(negedge Clk) begin : cmp
    logic [31:0] ir;
    logic [31:0] rs_v;
    logic [31:0] rt_v;
    logic [1:0]  sel;
    ir   = bus.IRD;
    rs_v = m_fwd(bus.FwdSelRS, m_read(ir[25:21]));
    rt_v = m_fwd(bus.FwdSelRT, m_read(ir[20:16]));
    if (e_valid) begin
      check("E.IRE", bus.IRE, x_ire);
      check("E.PC4E", bus.PC4E, x_pc4e);
      check("E.RSE", bus.RSE, x_rse);
      check("E.RTE", bus.RTE, x_rte);
      check("E.EXTE", bus.EXTE, x_exte);
      check("E.ExcCodeE", 32'(bus.ExcCodeE), 32'(x_exc));
    end
    if (m_valid && !Reset) begin
      sel = want_sel(ir);
      check("D.NPC_Sel", 32'(bus.NPC_Sel), 32'(sel));
      check("D.MF_RS_D_OUT", bus.MF_RS_D_OUT, rs_v);
      check("D.iseretD", 32'(bus.iseretD), 32'(ir == ERET));
      if (sel == 2'd1)
        check("D.Branch", 32'(bus.Branch), 32'(want_taken(ir, rs_v, rt_v)));
      if (sel == 2'd1 || sel == 2'd2)
        check("D.NPC", bus.NPC, want_npc(ir, bus.PC4D));
    end
    if (Reset) begin
      {x_ire, x_pc4e, x_rse, x_rte, x_exte} = '0;
      x_exc = '0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_regs[28] = 32'h0000_1800;
      m_regs[29] = 32'h0000_2ffc;
      m_valid = 1'b1;
      e_valid = 1'b1;
    end else if (m_valid) begin
      if (bus.exp_in || bus.StallD) begin
        {x_ire, x_pc4e, x_rse, x_rte, x_exte} = '0;
        x_exc = '0;
      end else begin
        x_ire  = legal(ir) ? ir : 32'h0;
        x_pc4e = bus.PC4D;
        x_rse  = rs_v;
        x_rte  = rt_v;
        x_exte = want_ext(ir);
        x_exc  = (bus.ExcCodeF != 5'd0) ? bus.ExcCodeF : (legal(ir) ? 5'd0 : 5'd10);
      end
      if (bus.WE_W && bus.WA_W != 5'd0) m_regs[bus.WA_W] = bus.WD_W;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    bus.IRD = '0; bus.PC4D = '0; bus.ExcCodeF = '0; bus.StallD = 1'b0; bus.exp_in = 1'b0;
    bus.FwdSelRS = '0; bus.FwdSelRT = '0; bus.FwdDataE = '0; bus.FwdDataM = '0;
    bus.WE_W = 1'b0; bus.WA_W = '0; bus.WD_W = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench did not finish");
  end

  // Per branch operand value: expected taken bits {blez, bgtz, bltz, bgez}.
  logic [31:0] bvals [4] = '{32'h0000_0000, 32'hffff_ffff, 32'h0000_0001, 32'h8000_0000};
  logic [3:0]  bexp  [4] = '{4'b1001, 4'b1010, 4'b0101, 4'b1010};

  initial begin
    logic [31:0] bops [4];
    logic [3:0]  e;
    Reset = 1'b1;
    idle();
    tick();
    // Write coincident with Reset must be dropped.
    bus.WE_W = 1'b1; bus.WA_W = 5'd5; bus.WD_W = 32'h0000_0123;
    bus.IRD = rtype(5'd1, 5'd2, 5'd9, 6'h21); bus.PC4D = 32'h3000;
    tick();
    check("rst.IRE", bus.IRE, 32'h0);
    check("rst.PC4E", bus.PC4E, 32'h0);
    check("rst.RSE", bus.RSE, 32'h0);
    check("rst.ExcCodeE", 32'(bus.ExcCodeE), 32'h0);
    Reset = 1'b0;
    idle();

    // Reset values of $29/$28.
    bus.IRD = rtype(5'd29, 5'd28, 5'd9, 6'h21); bus.PC4D = 32'h3004;
    tick();
    check("init.RSE_sp", bus.RSE, 32'h0000_2ffc);
    check("init.RTE_gp", bus.RTE, 32'h0000_1800);
    check("init.IRE", bus.IRE, rtype(5'd29, 5'd28, 5'd9, 6'h21));
    check("init.PC4E", bus.PC4E, 32'h3004);

    // Same-cycle write/read bypass.
    idle();
    bus.WE_W = 1'b1; bus.WA_W = 5'd8; bus.WD_W = 32'd5;
    bus.IRD = rtype(5'd8, 5'd0, 5'd9, 6'h21);
    tick();
    check("bypass.RSE", bus.RSE, 32'd5);

    // $0 never written nor bypassed; $5 write during reset was dropped.
    idle();
    bus.WE_W = 1'b1; bus.WA_W = 5'd0; bus.WD_W = 32'hffff_ffff;
    bus.IRD = rtype(5'd0, 5'd5, 5'd9, 6'h21);
    tick();
    check("zero.RSE", bus.RSE, 32'h0);
    check("dropped.RTE", bus.RTE, 32'h0);

    // beq taken backwards, then bne not taken.
    idle();
    bus.WE_W = 1'b1; bus.WA_W = 5'd1; bus.WD_W = 32'd7;
    tick();
    bus.WA_W = 5'd2; bus.WD_W = 32'd7;
    bus.IRD = itype(6'h04, 5'd1, 5'd2, 16'hffff); bus.PC4D = 32'h3004;
    #1;
    check("beq.NPC_Sel", 32'(bus.NPC_Sel), 32'd1);
    check("beq.Branch", 32'(bus.Branch), 32'd1);
    check("beq.NPC", bus.NPC, 32'h3000);
    tick();
    idle();
    bus.IRD = itype(6'h05, 5'd1, 5'd2, 16'h0004); bus.PC4D = 32'h3004;
    #1;
    check("bne.Branch", 32'(bus.Branch), 32'd0);
    check("bne.NPC", bus.NPC, 32'h3014);
    tick();

    // jr with all forwarding sources.
    idle();
    bus.WE_W = 1'b1; bus.WA_W = 5'd31; bus.WD_W = 32'h3010;
    tick();
    idle();
    bus.IRD = rtype(5'd31, 5'd0, 5'd0, 6'h08);
    bus.FwdSelRS = 2'd1; bus.FwdDataM = 32'h3020;
    #1;
    check("jr.NPC_Sel", 32'(bus.NPC_Sel), 32'd3);
    check("jr.fwdM", bus.MF_RS_D_OUT, 32'h3020);
    bus.FwdSelRS = 2'd3;
    #1;
    check("jr.sel3_rf", bus.MF_RS_D_OUT, 32'h3010);
    bus.FwdSelRS = 2'd2; bus.FwdDataE = 32'h4444;
    #1;
    check("jr.fwdE", bus.MF_RS_D_OUT, 32'h4444);
    tick();

    // j target keeps PC4D[31:28].
    idle();
    bus.IRD = {6'h02, 26'h000_0100}; bus.PC4D = 32'ha000_0000;
    #1;
    check("j.NPC_Sel", 32'(bus.NPC_Sel), 32'd2);
    check("j.NPC", bus.NPC, 32'ha000_0400);
    tick();

    // Signed zero-compare branches at boundary operand values.
    bops[0] = itype(6'h06, 5'd3, 5'd0, 16'h0010);
    bops[1] = itype(6'h07, 5'd3, 5'd0, 16'h0010);
    bops[2] = itype(6'h01, 5'd3, 5'd0, 16'h0010);
    bops[3] = itype(6'h01, 5'd3, 5'd1, 16'h0010);
    for (int v = 0; v < 4; v++) begin
      e = bexp[v];
      for (int k = 0; k < 4; k++) begin
        idle();
        bus.IRD = bops[k]; bus.PC4D = 32'h3100;
        bus.FwdSelRS = 2'd2; bus.FwdDataE = bvals[v];
        #1;
        check($sformatf("zbr.v%0d.k%0d", v, k), 32'(bus.Branch), 32'(e[3 - k]));
        tick();
      end
    end

    // Stall: bubble into E while the regfile write still lands.
    idle();
    bus.StallD = 1'b1;
    bus.IRD = itype(6'h0d, 5'd0, 5'd3, 16'h1234); bus.PC4D = 32'h3040;
    bus.WE_W = 1'b1; bus.WA_W = 5'd3; bus.WD_W = 32'h55;
    tick();
    check("stall.IRE", bus.IRE, 32'h0);
    check("stall.ExcCodeE", 32'(bus.ExcCodeE), 32'h0);
    check("stall.PC4E", bus.PC4E, 32'h0);
    idle();
    bus.IRD = rtype(5'd3, 5'd0, 5'd9, 6'h21);
    tick();
    check("stall.write", bus.RSE, 32'h55);

    // Immediate extension variants.
    idle();
    bus.IRD = itype(6'h0d, 5'd0, 5'd4, 16'h8001);
    tick();
    check("ext.ori", bus.EXTE, 32'h0000_8001);
    bus.IRD = itype(6'h0f, 5'd0, 5'd4, 16'h8001);
    tick();
    check("ext.lui", bus.EXTE, 32'h8001_0000);
    bus.IRD = itype(6'h09, 5'd0, 5'd4, 16'h8001);
    tick();
    check("ext.addiu", bus.EXTE, 32'hffff_8001);

    // Reserved instruction, then with an F-stage exception taking priority.
    idle();
    bus.IRD = 32'hfc00_0000; bus.PC4D = 32'h3050;
    tick();
    check("ri.ExcCodeE", 32'(bus.ExcCodeE), 32'd10);
    check("ri.IRE", bus.IRE, 32'h0);
    check("ri.PC4E", bus.PC4E, 32'h3050);
    bus.ExcCodeF = 5'd4;
    tick();
    check("ri.excF", 32'(bus.ExcCodeE), 32'd4);

    // Exception flush.
    idle();
    bus.IRD = rtype(5'd29, 5'd28, 5'd9, 6'h21); bus.PC4D = 32'h3060; bus.exp_in = 1'b1;
    tick();
    check("exp.IRE", bus.IRE, 32'h0);
    check("exp.PC4E", bus.PC4E, 32'h0);
    check("exp.RSE", bus.RSE, 32'h0);
    check("exp.RTE", bus.RTE, 32'h0);

    // eret is flagged but does not redirect through NPC_Sel.
    idle();
    bus.IRD = ERET;
    #1;
    check("eret.iseretD", 32'(bus.iseretD), 32'd1);
    check("eret.NPC_Sel", 32'(bus.NPC_Sel), 32'd0);
    tick();

    // Reset mid-operation: regfile reinitialised, concurrent write dropped.
    idle();
    bus.WE_W = 1'b1; bus.WA_W = 5'd7; bus.WD_W = 32'h77;
    tick();
    Reset = 1'b1;
    bus.WA_W = 5'd28; bus.WD_W = 32'h0000_dead;
    bus.IRD = rtype(5'd29, 5'd7, 5'd9, 6'h21); bus.PC4D = 32'h3070;
    tick();
    check("rst2.IRE", bus.IRE, 32'h0);
    Reset = 1'b0;
    idle();
    bus.IRD = rtype(5'd28, 5'd7, 5'd9, 6'h21);
    tick();
    check("rst2.gp", bus.RSE, 32'h0000_1800);
    check("rst2.r7", bus.RTE, 32'h0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
